pwm_edge_logger: RTL and testbench

PWM_EDGE_LOGGER -- requirements
Module: pwm_edge_logger

---
 rtl/pwm_edge_logger.sv | 242 ++++++++++++++++++++++++
 tb/tb_pwm_edge_logger.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_edge_logger.sv
// PWM edge logger: snapshots enabled channel levels at session start/end and
// timestamps every level change in between into a first-word-fallthrough record FIFO.
// Optional macro PWM_LOG_OVF_COUNT_EN adds an 8-bit saturating dropped-edge counter (ovf_cnt).
module pwm_edge_logger #(
  parameter int CH    = 4,
  parameter int TS_W  = 24,
  parameter int DEPTH = 16,
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   pwm_in,
  input  logic [CH-1:0]   ch_mask,
  input  logic [TS_W-1:0] win_len,
  input  logic            arm,
  output logic            busy,
  output logic            done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TS_W-1:0] out_ts,
  output logic [CH_W-1:0] out_ch,
  output logic            out_level,
  output logic            overflow
`ifdef PWM_LOG_OVF_COUNT_EN
  ,
  output logic [7:0]      ovf_cnt
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = TS_W + CH_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_FINAL = 2'd3;

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(CH - 1);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [CH_W-1:0]  idx_q, idx_d;
  logic [TS_W-1:0]  cnt_q, cnt_d;
  logic [CH-1:0]    mask_q;
  logic [TS_W-1:0]  win_q;
  logic [CH-1:0]    pwm_q, prev_q;
  logic [CH-1:0]    pend_v_q, pend_v_d;
  logic [TS_W-1:0]  pend_ts_q [CH];
  logic [CH-1:0]    pend_lvl_q;
  logic             overflow_q;
  logic             done_q, done_d;

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fill_q;
  logic [REC_W-1:0] rd_rec;

  logic             fifo_full, fifo_empty, pop, can_push, push, advance;
  logic [REC_W-1:0] push_rec;
  logic [CH-1:0]    edge_raw, new_edge, drop_vec, cand, load_pend;
  logic             win_found;
  logic [CH_W-1:0]  win_idx;

`ifdef PWM_LOG_OVF_COUNT_EN
  logic [7:0] ovf_cnt_q;

  function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [CH-1:0] hits);
    int sum;
    sum = int'(acc) + $countones(hits);
    return (sum > 255) ? 8'd255 : sum[7:0];
  endfunction

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign fifo_full  = (fill_q == FULL_CNT);
  assign fifo_empty = (fill_q == '0);
  assign pop        = !fifo_empty && out_ready;
  // A full FIFO still accepts a record in a cycle where its head leaves.
  assign can_push   = !fifo_full || pop;

  assign edge_raw = (state_q == S_CAPT) ? ((pwm_q ^ prev_q) & mask_q) : '0;
  assign new_edge = edge_raw & ~pend_v_q;
  assign drop_vec = edge_raw & pend_v_q;
  assign cand     = pend_v_q | new_edge;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pend_v_d  = pend_v_q;
    load_pend = new_edge;
    push      = 1'b0;
    push_rec  = '0;
    done_d    = 1'b0;
    advance   = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(i);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      end
      S_INIT: begin
        if (!mask_q[idx_q]) begin
          advance = 1'b1;
        end else if (can_push) begin
          push     = 1'b1;
          push_rec = {{TS_W{1'b0}}, idx_q, pwm_q[idx_q]};
          advance  = 1'b1;
        end
        if (advance) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = (win_q == '0) ? S_FINAL : S_CAPT;
          end else begin
            idx_d = idx_q + CH_W'(1);
          end
        end
      end
      S_CAPT: begin
        cnt_d = cnt_q + TS_W'(1);
        if (cnt_q == win_q - TS_W'(1)) begin
          state_d = S_FINAL;
          idx_d   = '0;
        end
      end
      default: begin
        // Closing snapshot waits until every pending edge has reached the FIFO.
        if (pend_v_q == '0) begin
          if (!mask_q[idx_q]) begin
            advance = 1'b1;
          end else if (can_push) begin
            push     = 1'b1;
            push_rec = {win_q, idx_q, pwm_q[idx_q]};
            advance  = 1'b1;
          end
          if (advance) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + CH_W'(1);
            end
          end
        end
      end
    endcase

    if ((state_q == S_CAPT || state_q == S_FINAL) && win_found && can_push) begin
      push = 1'b1;
      if (pend_v_q[win_idx]) begin
        push_rec          = {pend_ts_q[win_idx], win_idx, pend_lvl_q[win_idx]};
        pend_v_d[win_idx] = 1'b0;
      end else begin
        push_rec           = {cnt_q, win_idx, pwm_q[win_idx]};
        load_pend[win_idx] = 1'b0;
      end
    end
    pend_v_d = pend_v_d | load_pend;
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      win_q      <= '0;
      pend_v_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
`ifdef PWM_LOG_OVF_COUNT_EN
      ovf_cnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pend_v_q <= pend_v_d;
      done_q   <= done_d;
      if (state_q == S_IDLE && arm) begin
        mask_q     <= ch_mask;
        win_q      <= win_len;
        overflow_q <= 1'b0;
`ifdef PWM_LOG_OVF_COUNT_EN
        ovf_cnt_q  <= '0;
`endif
      end else if (|drop_vec) begin
        overflow_q <= 1'b1;
`ifdef PWM_LOG_OVF_COUNT_EN
        ovf_cnt_q  <= sat_add8(ovf_cnt_q, drop_vec);
`endif
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + (AW + 1)'(1);
        2'b01:   fill_q <= fill_q - (AW + 1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    pwm_q  <= pwm_in;
    prev_q <= pwm_q;
    if (push) mem[wr_ptr_q] <= push_rec;
    for (int i = 0; i < CH; i++) begin
      if (load_pend[i]) begin
        pend_ts_q[i]  <= cnt_q;
        pend_lvl_q[i] <= pwm_q[i];
      end
    end
  end

  assign rd_rec    = mem[rd_ptr_q];
  assign out_valid = !fifo_empty;
  assign out_ts    = out_valid ? rd_rec[REC_W-1 -: TS_W] : '0;
  assign out_ch    = out_valid ? rd_rec[CH_W:1] : '0;
  assign out_level = out_valid ? rd_rec[0] : 1'b0;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pwm_edge_logger.sv
// Self-checking bench for pwm_edge_logger: table of static-level sessions plus
// hand-written edge, burst, overflow, reset and re-arm sequences, scoreboard on the FIFO output.
module tb_pwm_edge_logger;
  localparam int CH    = 4;
  localparam int TS_W  = 24;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   pwm_in;
  logic [CH-1:0]   ch_mask;
  logic [TS_W-1:0] win_len;
  logic            arm;
  logic            busy, done, out_valid, out_ready, out_level, overflow;
  logic [TS_W-1:0] out_ts;
  logic [1:0]      out_ch;
`ifdef PWM_LOG_OVF_COUNT_EN
  logic [7:0]      ovf_cnt;
`endif

  always #5 clk = ~clk;

  pwm_edge_logger #(.CH(CH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .ch_mask(ch_mask), .win_len(win_len),
    .arm(arm), .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_ts(out_ts), .out_ch(out_ch), .out_level(out_level), .overflow(overflow)
`ifdef PWM_LOG_OVF_COUNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [1:0]      ch;
    logic            lvl;
  } rec_t;

  typedef struct packed {
    logic [CH-1:0]   mask;
    logic [TS_W-1:0] win;
    logic [CH-1:0]   pwm;
  } sess_t;

  rec_t  exp_q[$];
  rec_t  mon_e;
  sess_t tab[5];
  int    total = 0;
  int    bad = 0;
  int    done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every handshake pops one expected record.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      check("busy_low_at_done", busy, 0);
    end
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_record actual=ts%0d/ch%0d/lvl%0d required=none", out_ts, out_ch, out_level);
      end else begin
        mon_e = exp_q.pop_front();
        check("rec_ts", out_ts, mon_e.ts);
        check("rec_ch", out_ch, mon_e.ch);
        check("rec_level", out_level, mon_e.lvl);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ts, input int ch, input logic lvl);
    rec_t r;
    r.ts  = TS_W'(ts);
    r.ch  = 2'(ch);
    r.lvl = lvl;
    exp_q.push_back(r);
  endtask

  task automatic snap_exp(input logic [CH-1:0] mask, input int ts, input logic [CH-1:0] lvl);
    for (int c = 0; c < CH; c++) if (mask[c]) push_exp(ts, c, lvl[c]);
  endtask

  // Leaves the bench one cycle after the cycle in which arm was sampled.
  task automatic arm_session(input logic [CH-1:0] mask, input int win);
    ch_mask = mask;
    win_len = TS_W'(win);
    arm     = 1'b1;
    tick(1);
    arm     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int start_cnt, input int budget);
    int n = 0;
    while (done_seen == start_cnt && n < budget) begin
      tick(1);
      n++;
    end
    if (done_seen == start_cnt) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_done required=done_within_%0d", name, budget);
    end
    tick(5);
    check({name, "_done_once"}, done_seen - start_cnt, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_idle"}, busy, 0);
  endtask

  task automatic run_static(input sess_t s, input string name);
    int d0;
    pwm_in = s.pwm;
    tick(3);
    snap_exp(s.mask, 0, s.pwm);
    snap_exp(s.mask, int'(s.win), s.pwm);
    d0 = done_seen;
    arm_session(s.mask, int'(s.win));
    check({name, "_busy"}, busy, 1);
    wait_done(name, d0, 1000);
    check({name, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int d0;
    tab[0] = '{mask: 4'b0011, win: 24'd100, pwm: 4'b0001};
    tab[1] = '{mask: 4'b1111, win: 24'd1,   pwm: 4'b1010};
    tab[2] = '{mask: 4'b1010, win: 24'd3,   pwm: 4'b0110};
    tab[3] = '{mask: 4'b0000, win: 24'd5,   pwm: 4'b1111};
    tab[4] = '{mask: 4'b0101, win: 24'd0,   pwm: 4'b0011};

    rst = 1'b1; pwm_in = '0; ch_mask = '0; win_len = '0; arm = 1'b0; out_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_ts", out_ts, 0);

    for (int i = 0; i < 5; i++) run_static(tab[i], $sformatf("tab%0d", i));

    // Two ch0 edges detected at ts=10 and ts=30.
    pwm_in = '0;
    tick(3);
    push_exp(0, 0, 1'b0); push_exp(10, 0, 1'b1); push_exp(30, 0, 1'b0); push_exp(50, 0, 1'b0);
    d0 = done_seen;
    arm_session(4'b0001, 50);
    tick(CH + 9);
    pwm_in = 4'b0001;
    tick(1);
    check("edge_lat_cyc1_valid", out_valid, 0);
    tick(1);
    check("edge_lat_cyc2_valid", out_valid, 1);
    check("edge_lat_cyc2_ts", out_ts, 10);
    tick(18);
    pwm_in = 4'b0000;
    wait_done("edges", d0, 1000);

    // All four channels change together, detected at ts=5.
    pwm_in = '0;
    tick(3);
    snap_exp(4'hF, 0, 4'h0);
    snap_exp(4'hF, 5, 4'hF);
    snap_exp(4'hF, 20, 4'hF);
    d0 = done_seen;
    arm_session(4'hF, 20);
    tick(CH + 4);
    pwm_in = 4'hF;
    tick(2);
    for (int c = 0; c < CH; c++) begin
      check("burst_valid", out_valid, 1);
      check("burst_ts", out_ts, 5);
      check("burst_ch", out_ch, c);
      tick(1);
    end
    wait_done("burst", d0, 1000);
    check("burst_overflow", overflow, 0);

    // FIFO fills with out_ready low: 15 edges fit, the 16th waits pending, 4 are dropped.
    pwm_in = '0;
    out_ready = 1'b0;
    tick(3);
    push_exp(0, 0, 1'b0);
    for (int j = 0; j < 15; j++) push_exp(2 + 2 * j, 0, (j % 2) == 0);
    push_exp(32, 0, 1'b0);
    push_exp(100, 0, 1'b0);
    d0 = done_seen;
    arm_session(4'b0001, 100);
    tick(CH + 1);
    for (int j = 0; j < 20; j++) begin
      pwm_in[0] = ~pwm_in[0];
      tick(2);
    end
    tick(5);
    check("ovf_flag", overflow, 1);
    check("ovf_busy", busy, 1);
    check("ovf_head_valid", out_valid, 1);
    check("ovf_head_ts", out_ts, 0);
    check("ovf_head_level", out_level, 0);
`ifdef PWM_LOG_OVF_COUNT_EN
    check("ovf_cnt", ovf_cnt, 4);
`endif
    out_ready = 1'b1;
    wait_done("ovf", d0, 1000);
    check("ovf_sticky", overflow, 1);

    // Reset in the middle of CAPTURE with three records waiting.
    pwm_in = '0;
    out_ready = 1'b0;
    tick(3);
    arm_session(4'b0111, 100);
    tick(CH + 20);
    check("prerst_valid", out_valid, 1);
    check("prerst_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_ch", out_ch, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    out_ready = 1'b1;
    tick(2);
    run_static(tab[0], "post_rst");

    // Second arm while busy is ignored; zero-length window.
    pwm_in = 4'b1000;
    tick(3);
    snap_exp(4'b1001, 0, 4'b1000);
    snap_exp(4'b1001, 0, 4'b1000);
    d0 = done_seen;
    arm_session(4'b1001, 0);
    ch_mask = 4'hF;
    win_len = 24'd7;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    wait_done("rearm", d0, 1000);
    tick(20);
    check("rearm_still_idle", busy, 0);
    check("rearm_single_done", done_seen - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
